duty_cycle_check: RTL and testbench
===================================

Name: duty_cycle_check

Overview:
- Simulation-only checker for the PLL model. Measures the high phase of a monitored clock against a target duty cycle.
- Monitored clock: `clk`, nominal period `clk_period` ns, target duty `desired_duty_cycle`.
- Asserts `fail` when a measured high phase deviates beyond tolerance while the PLL reports `LOCKED`.
- Instantiated per PLL output (CLKOUTn) in output-verification benches. Behavioural code: uses `$realtime` under `timescale 1 ns / 1 ps`. Not synthesizable.

Parameters:
- desired_duty_cycle, 0.5, real: target high fraction of the period; legal range (0.0, 1.0).
- clk_period, 10, real: nominal period of `clk` in ns; must be > 0.
- tolerance, 0.1, real: maximum allowed |measured high time − expected high time|, in ns.

Ports:
- clk  input  1  monitored clock; both edges are used.
- reset  input  1  asynchronous, active-high reset.
- LOCKED  input  1  PLL lock indicator; measurements count only while high.
- fail  output  1  sticky error flag; 1 = duty-cycle violation detected.

Behaviour:
- Reset (asynchronous, active-high): `fail` = 0 immediately on `reset` rising.
  - Clears stored rise timestamp and its valid flag (and period timestamp/flag when PERIOD_CHECK_EN is defined).
  - While `reset` = 1, all edges are ignored and `fail` stays 0.
- Expected high time: `exp_high` = `desired_duty_cycle` * `clk_period` (real, ns), computed once.
- Posedge `clk` with `reset` = 0 and `LOCKED` = 1: store `t_rise` = `$realtime`; set `rise_valid` = 1.
- Posedge `clk` with `LOCKED` = 0: set `rise_valid` = 0; `t_rise` is not stored.
- Negedge `clk` with `reset` = 0, `LOCKED` = 1 and `rise_valid` = 1:
  - `high` = `$realtime` − `t_rise`.
  - If |`high` − `exp_high`| > `tolerance`, `fail` <= 1.
- Negedge `clk` otherwise: no measurement.
- Warm-up: the first complete high phase after `LOCKED` rises is measured only if its rising edge occurred with `LOCKED` already 1. A partial phase straddling `LOCKED` rising is never evaluated.
- `LOCKED` falling: set `rise_valid` = 0 at once; `fail` keeps its value (sticky).
- `fail` is sticky: once 1, it stays 1 until `reset`. No other event clears it.
- Boundary case, deviation exactly equal to `tolerance`: pass (strict `>` comparison).
- Simultaneous `reset` rising with a `clk` edge: reset wins; no measurement that timestep.
- Reset mid-phase: the in-progress measurement is discarded. After release, a fresh posedge is required before any check.
- `fail` changes only at a negedge of `clk` (to 1) or at `reset` (to 0).
- `$display` on each failure: time, measured high, expected high.

Optional Feature:
- Macro: DUTY_CYCLE_CHECK_PERIOD_CHECK_EN.
- Defined:
  - Each qualified posedge (`LOCKED` = 1, previous posedge also qualified) also measures `period` = `$realtime` − previous `t_rise`.
  - `fail` <= 1 if |`period` − `clk_period`| > `tolerance`.
  - Previous-rise valid flag obeys the same reset and `LOCKED` clearing rules as `rise_valid`.
- Undefined: only the high phase is checked; no period logic is compiled in.

Test Plan:
- Reset: start `clk` (10 ns, 50 %), `reset` = 1 for 10 ns → `fail` = 0 during and after reset.
- Unlocked: `reset` = 0, `LOCKED` = 0, run 30 ns with a 30 % duty clock → `fail` stays 0.
- Match: `LOCKED` = 1, 50 % duty (5 ns high), run 1000 ns → `fail` = 0 throughout.
- Mismatch: switch to 40 % duty (4 ns high, deviation 1 ns > 0.1 ns), run 1000 ns → `fail` = 1 from the first fully measured high phase and stays 1; then assert `reset` → `fail` = 0 immediately.
- Tolerance edge: high time 5.1 ns → `fail` = 0; high time 5.2 ns → `fail` = 1.
- Lock drop / period option: `LOCKED` low mid-high-phase, then high again → no check of the straddling phase, `fail` = 0. With DUTY_CYCLE_CHECK_PERIOD_CHECK_EN defined and `clk` at 11 ns period / 5.5 ns high, `desired_duty_cycle` = 0.5 → `fail` = 1.

Source files
------------

// File: rtl/duty_cycle_check.sv
`timescale 1ns / 1ps
// Behavioural duty-cycle checker for one PLL output clock: raises a sticky fail when a fully
// observed high phase misses the target while LOCKED is high. Macro DUTY_CYCLE_CHECK_PERIOD_CHECK_EN adds a period check.
module duty_cycle_check #(
   parameter real desired_duty_cycle = 0.5,
   parameter real clk_period         = 10.0,
   parameter real tolerance          = 0.1
) (
   input  logic clk,
   input  logic reset,
   input  logic LOCKED,
   output logic fail
);

   localparam real    ExpHigh   = desired_duty_cycle * clk_period;
   // Comparisons are done in whole picoseconds so a deviation of exactly the tolerance passes
   // despite floating-point residue from subtracting absolute timestamps.
   localparam longint ExpHighPs = longint'($floor(ExpHigh * 1000.0 + 0.5));
   localparam longint TolPs     = longint'($floor(tolerance * 1000.0 + 0.5));
`ifdef DUTY_CYCLE_CHECK_PERIOD_CHECK_EN
   localparam longint PeriodPs  = longint'($floor(clk_period * 1000.0 + 0.5));
`endif

   realtime tRise_q;
   logic    riseValid_q;
   logic    fail_q;

   function automatic logic outOfTol(input real measNs, input longint expPs);
      longint measPs;
      measPs = longint'($floor(measNs * 1000.0 + 0.5));
      return ((measPs - expPs) > TolPs) || ((expPs - measPs) > TolPs);
   endfunction

   // Both clock edges plus LOCKED falling: a lock drop mid-phase must invalidate the stored rise
   // at once, and riseValid_q doubles as the "previous posedge was qualified" flag for the period check.
   always_ff @(posedge clk or negedge clk or posedge reset or negedge LOCKED) begin
      if (reset) begin
         fail_q      <= 1'b0;
         riseValid_q <= 1'b0;
         tRise_q     <= 0.0;
      end else if (!LOCKED) begin
         riseValid_q <= 1'b0;
      end else if (clk) begin
`ifdef DUTY_CYCLE_CHECK_PERIOD_CHECK_EN
         if (riseValid_q && outOfTol($realtime - tRise_q, PeriodPs)) begin
            fail_q <= 1'b1;
            $display("[duty_cycle_check] period violation at %0t: measured %f ns, expected %f ns",
                     $realtime, $realtime - tRise_q, clk_period);
         end
`endif
         tRise_q     <= $realtime;
         riseValid_q <= 1'b1;
      end else if (riseValid_q && outOfTol($realtime - tRise_q, ExpHighPs)) begin
         fail_q <= 1'b1;
         $display("[duty_cycle_check] duty violation at %0t: measured high %f ns, expected high %f ns",
                  $realtime, $realtime - tRise_q, ExpHigh);
      end
   end

   assign fail = fail_q;

endmodule

// File: tb/tb_duty_cycle_check.sv
`timescale 1ns / 1ps
// Self-checking bench for duty_cycle_check: table of clock shapes plus hand-written lock/reset corner sequences.
module tb_duty_cycle_check;

   logic clk;
   logic reset  = 1'b1;
   logic LOCKED = 1'b0;
   logic fail;

   real highT = 5.0;
   real lowT  = 5.0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string name;
      real   highT;
      real   lowT;
      logic  locked;
      int    cycles;
      int    failFrom;
   } vec_t;

   typedef struct {
      string name;
      logic  exp;
   } exp_t;

   exp_t expQ[$];
   vec_t vecs[10];

   duty_cycle_check #(
      .desired_duty_cycle(0.5),
      .clk_period(10.0),
      .tolerance(0.1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .LOCKED(LOCKED),
      .fail(fail)
   );

   // Shape changes made during a low phase take effect from the next rising edge.
   always begin
      clk = 1'b1;
      #(highT);
      clk = 1'b0;
      #(lowT);
   end

   task automatic pushExp(input string n, input logic e);
      exp_t item;
      item.name = n;
      item.exp  = e;
      expQ.push_back(item);
   endtask

   task automatic checkOutput();
      exp_t item;
      checks++;
      if (expQ.size() == 0) begin
         errors++;
         $display("[TB] FAIL scoreboard: no expected value queued, fail=%b at %0t", fail, $time);
      end else begin
         item = expQ.pop_front();
         if (fail !== item.exp) begin
            errors++;
            $display("[TB] FAIL %s: fail=%b, expected %b at %0t", item.name, fail, item.exp, $time);
         end
      end
   endtask

   // Reset the checker while switching to a new shape, then check every following cycle.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      reset  = 1'b1;
      highT  = v.highT;
      lowT   = v.lowT;
      LOCKED = v.locked;
      #0.5;
      pushExp({v.name, "-resetClear"}, 1'b0);
      checkOutput();
      @(negedge clk);
      reset = 1'b0;
      for (int i = 1; i <= v.cycles; i++) begin
         @(negedge clk);
         pushExp(v.name, (v.failFrom > 0 && i >= v.failFrom) ? 1'b1 : 1'b0);
         #1;
         checkOutput();
      end
   endtask

   task automatic sampleNextNegedge(input string n, input logic e);
      pushExp(n, e);
      @(negedge clk);
      #1;
      checkOutput();
   endtask

   initial begin
      #600000;
      $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int periodFailFrom;
`ifdef DUTY_CYCLE_CHECK_PERIOD_CHECK_EN
      periodFailFrom = 2;
`else
      periodFailFrom = 0;
`endif
      vecs[0] = '{"unlocked30",  3.0, 7.0, 1'b0,   3, 0};
      vecs[1] = '{"match50",     5.0, 5.0, 1'b1, 100, 0};
      vecs[2] = '{"duty40",      4.0, 6.0, 1'b1, 100, 1};
      vecs[3] = '{"tolEdgeHi",   5.1, 4.9, 1'b1,  20, 0};
      vecs[4] = '{"tolOverHi",   5.2, 4.8, 1'b1,  20, 1};
      vecs[5] = '{"tolEdgeLo",   4.9, 5.1, 1'b1,  20, 0};
      vecs[6] = '{"tolOverLo",   4.8, 5.2, 1'b1,  20, 1};
      vecs[7] = '{"duty60",      6.0, 4.0, 1'b1,  20, 1};
      vecs[8] = '{"period11",    5.0, 6.0, 1'b1,  20, periodFailFrom};
      vecs[9] = '{"unlockedBad", 2.0, 8.0, 1'b0,  20, 0};

      #3;
      pushExp("duringReset", 1'b0);
      checkOutput();

      foreach (vecs[k]) applyStimulus(vecs[k]);

      // LOCKED rises mid-high-phase: that straddling phase must not be judged.
      applyStimulus('{"straddlePre", 4.0, 6.0, 1'b0, 3, 0});
      @(posedge clk);
      #1;
      LOCKED = 1'b1;
      sampleNextNegedge("straddle", 1'b0);
      sampleNextNegedge("afterStraddle", 1'b1);

      // Brief lock drop inside a bad high phase discards it.
      applyStimulus('{"blipPre", 5.0, 5.0, 1'b1, 5, 0});
      highT = 4.0;
      lowT  = 6.0;
      @(posedge clk);
      #1;
      LOCKED = 1'b0;
      #1;
      LOCKED = 1'b1;
      sampleNextNegedge("lockBlip", 1'b0);
      sampleNextNegedge("afterBlip", 1'b1);

      // Reset pulse inside a bad high phase discards the measurement.
      applyStimulus('{"midResetPre", 5.0, 5.0, 1'b1, 5, 0});
      highT = 4.0;
      lowT  = 6.0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      #0.5;
      pushExp("midResetClear", 1'b0);
      checkOutput();
      #0.5;
      reset = 1'b0;
      sampleNextNegedge("midReset", 1'b0);
      sampleNextNegedge("afterMidReset", 1'b1);

      // Sticky across lock loss and good clocks; only reset clears it.
      highT = 5.0;
      lowT  = 5.0;
      @(posedge clk);
      #1;
      LOCKED = 1'b0;
      for (int i = 0; i < 5; i++) sampleNextNegedge("stickyUnlocked", 1'b1);
      LOCKED = 1'b1;
      for (int i = 0; i < 5; i++) sampleNextNegedge("stickyGood", 1'b1);
      reset = 1'b1;
      #0.5;
      pushExp("resetClearsSticky", 1'b0);
      checkOutput();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) sampleNextNegedge("afterFinalReset", 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
